// File: rtl/instr_decode_rv_queued.sv
// RV32I decode stage: {instr, pc} queue, registered control bundle, flush, sticky illegal trap.
// Defining ICE_RISCV_M_EXT_EN makes OP/funct7=0000001 decode as the M-extension ops.
module instr_decode_rv_queued #(
    parameter int QUEUE_DEPTH = 4,
    parameter int PC_WIDTH    = 32
) (
    input  logic                         iwClk,
    input  logic                         iwRst,
    input  logic                         iwInstrValid,
    input  logic [31:0]                  iwInstr,
    input  logic [PC_WIDTH-1:0]          iwPc,
    output logic                         owInstrReady,
    input  logic                         iwFlush,
    output logic                         owValid,
    input  logic                         iwReady,
    output logic [PC_WIDTH-1:0]          owPc,
    output logic [5:0]                   orAluOp,
    output logic                         owAluBSrc,
    output logic [31:0]                  owAluBImmediate,
    output logic                         owBranchInverted,
    output logic [4:0]                   owReadReg1,
    output logic [4:0]                   owReadReg2,
    output logic [4:0]                   owWriteReg,
    output logic [1:0]                   owWriteRegSource,
    output logic [31:0]                  orWriteRegImmediate,
    output logic                         owDMemWrite,
    output logic                         owDMemSignExtend,
    output logic [1:0]                   owDMemAccess,
    output logic [1:0]                   owNextPcSrc,
    output logic [19:0]                  owNextPcImmediate20,
    output logic [11:0]                  owNextPcImmediate12,
    output logic                         owIllegal,
    output logic [$clog2(QUEUE_DEPTH):0] owLevel
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [5:0] ALU_OP_ADD = 6'd0, ALU_OP_SUB = 6'd1, ALU_OP_SLL = 6'd2, ALU_OP_SLT = 6'd3;
    localparam logic [5:0] ALU_OP_SLTU = 6'd4, ALU_OP_XOR = 6'd5, ALU_OP_SRL = 6'd6, ALU_OP_SRA = 6'd7;
    localparam logic [5:0] ALU_OP_OR = 6'd8, ALU_OP_AND = 6'd9, ALU_OP_MUL = 6'd10;
    localparam logic       ALU_B_SOURCE_IMMEDIATE = 1'b1;
    localparam logic [1:0] REG_SOURCE_MEMORY = 2'd1, REG_SOURCE_IMMEDIATE = 2'd2;
    localparam logic [1:0] NEXT_PC_SRC_JAL = 2'd1, NEXT_PC_SRC_JALR = 2'd2, NEXT_PC_SRC_B = 2'd3;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OP_IMM = 7'b0010011, OPC_OP = 7'b0110011;

    typedef enum logic {RUN, TRAP} state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [5:0]          alu_op;
        logic                b_src;
        logic [31:0]         b_imm;
        logic                br_inv;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [1:0]          wsrc;
        logic [31:0]         wimm;
        logic                dmw;
        logic                dse;
        logic [1:0]          dacc;
        logic [1:0]          npc;
        logic [19:0]         i20;
        logic [11:0]         i12;
        logic                ill;
    } bundle_t;

    function automatic logic [5:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = ALU_OP_ADD;
            3'b001:  base_op = ALU_OP_SLL;
            3'b010:  base_op = ALU_OP_SLT;
            3'b011:  base_op = ALU_OP_SLTU;
            3'b100:  base_op = ALU_OP_XOR;
            3'b101:  base_op = ALU_OP_SRL;
            3'b110:  base_op = ALU_OP_OR;
            default: base_op = ALU_OP_AND;
        endcase
    endfunction

    logic [31:0]         q_instr [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [LVL_W-1:0]    level;
    state_t              state;
    bundle_t             out, dec;
    logic                out_valid, push, load, accept, legal;
    logic [31:0]         head_instr, pc32, imm_i, imm_s;
    logic [PC_WIDTH-1:0] head_pc;
    logic [2:0]          f3;
    logic [6:0]          f7;

    assign owInstrReady = !iwRst && (state == RUN) && (level < LVL_W'(QUEUE_DEPTH)) && !iwFlush;
    assign push   = iwInstrValid && owInstrReady;
    assign accept = out_valid && iwReady;
    // An accepted illegal bundle freezes the queue, so nothing new may be loaded behind it.
    assign load   = (state == RUN) && (level != '0) && (!out_valid || iwReady)
                    && !(accept && out.ill) && !iwFlush;

    assign head_instr = q_instr[rd_ptr];
    assign head_pc    = q_pc[rd_ptr];

    always_comb begin
        f3    = head_instr[14:12];
        f7    = head_instr[31:25];
        pc32  = 32'(head_pc);
        imm_i = {{20{head_instr[31]}}, head_instr[31:20]};
        imm_s = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
        legal = 1'b1;
        dec        = '0;
        dec.pc     = head_pc;
        dec.rs1    = head_instr[19:15];
        dec.rs2    = head_instr[24:20];
        dec.i20    = {head_instr[31], head_instr[19:12], head_instr[20], head_instr[30:21]};
        dec.i12    = head_instr[31:20];
        dec.alu_op = ALU_OP_ADD;
        case (head_instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                dec.rd   = head_instr[11:7];
                dec.wsrc = REG_SOURCE_IMMEDIATE;
                dec.wimm = {head_instr[31:12], 12'h000}
                           + ((head_instr[6:0] == OPC_AUIPC) ? pc32 : 32'd0);
            end
            OPC_JAL, OPC_JALR: begin
                dec.rd   = head_instr[11:7];
                dec.wsrc = REG_SOURCE_IMMEDIATE;
                dec.wimm = pc32 + 32'd4;
                dec.npc  = NEXT_PC_SRC_JAL;
                if (head_instr[6:0] == OPC_JALR) begin
                    legal     = (f3 == 3'b000);
                    dec.npc   = NEXT_PC_SRC_JALR;
                    dec.b_src = ALU_B_SOURCE_IMMEDIATE;
                    dec.b_imm = imm_i;
                end
            end
            OPC_BRANCH: begin
                dec.npc    = NEXT_PC_SRC_B;
                dec.i12    = {head_instr[31], head_instr[7], head_instr[30:25], head_instr[11:8]};
                dec.br_inv = f3[0];
                case (f3[2:1])
                    2'b00:   dec.alu_op = ALU_OP_SUB;
                    2'b10:   dec.alu_op = ALU_OP_SLT;
                    2'b11:   dec.alu_op = ALU_OP_SLTU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal     = (f3[1:0] != 2'b11) && (f3 != 3'b110);
                dec.rd    = head_instr[11:7];
                dec.wsrc  = REG_SOURCE_MEMORY;
                dec.b_src = ALU_B_SOURCE_IMMEDIATE;
                dec.b_imm = imm_i;
                dec.dse   = !f3[2];
                dec.dacc  = f3[1:0];
            end
            OPC_STORE: begin
                legal     = !f3[2] && (f3[1:0] != 2'b11);
                dec.dmw   = 1'b1;
                dec.b_src = ALU_B_SOURCE_IMMEDIATE;
                dec.b_imm = imm_s;
                dec.dacc  = f3[1:0];
            end
            OPC_OP_IMM: begin
                dec.rd     = head_instr[11:7];
                dec.b_src  = ALU_B_SOURCE_IMMEDIATE;
                dec.b_imm  = imm_i;
                dec.alu_op = base_op(f3);
                if (f3 == 3'b001) legal = (f7 == 7'b0000000);
                if (f3 == 3'b101) begin
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    if (f7[5]) dec.alu_op = ALU_OP_SRA;
                end
            end
            OPC_OP: begin
                dec.rd = head_instr[11:7];
                case (f7)
                    7'b0000000: dec.alu_op = base_op(f3);
                    7'b0100000: begin
                        if (f3 == 3'b000)      dec.alu_op = ALU_OP_SUB;
                        else if (f3 == 3'b101) dec.alu_op = ALU_OP_SRA;
                        else                   legal = 1'b0;
                    end
`ifdef ICE_RISCV_M_EXT_EN
                    7'b0000001: dec.alu_op = ALU_OP_MUL + 6'(f3);
`endif
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec     = '0;
            dec.pc  = head_pc;
            dec.rs1 = head_instr[19:15];
            dec.rs2 = head_instr[24:20];
            dec.ill = 1'b1;
        end
    end

    always_ff @(posedge iwClk) begin
        if (push) begin
            q_instr[wr_ptr] <= iwInstr;
            q_pc[wr_ptr]    <= iwPc;
        end
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            state     <= RUN;
        end else if (iwFlush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            state     <= RUN;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                out       <= dec;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (push && !load)      level <= level + LVL_W'(1);
            else if (load && !push) level <= level - LVL_W'(1);
            if (accept && out.ill) state <= TRAP;
        end
    end

    assign owValid             = out_valid;
    assign owPc                = out.pc;
    assign orAluOp             = out.alu_op;
    assign owAluBSrc           = out.b_src;
    assign owAluBImmediate     = out.b_imm;
    assign owBranchInverted    = out.br_inv;
    assign owReadReg1          = out.rs1;
    assign owReadReg2          = out.rs2;
    assign owWriteReg          = out.rd;
    assign owWriteRegSource    = out.wsrc;
    assign orWriteRegImmediate = out.wimm;
    assign owDMemWrite         = out.dmw;
    assign owDMemSignExtend    = out.dse;
    assign owDMemAccess        = out.dacc;
    assign owNextPcSrc         = out.npc;
    assign owNextPcImmediate20 = out.i20;
    assign owNextPcImmediate12 = out.i12;
    assign owIllegal           = out.ill;
    assign owLevel             = level;
endmodule

// File: tb/tb_instr_decode_rv_queued.sv
// Bench for instr_decode_rv_queued: scoreboard of expected bundles plus an occupancy/trap model.
module tb_instr_decode_rv_queued;
    localparam int D = 4;
    localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SLTU = 4, A_SRL = 6, A_SRA = 7, A_MUL = 10;
    localparam int BASE [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    localparam logic [6:0] OPCS [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
`ifdef ICE_RISCV_M_EXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  alu_op;
        logic        b_src;
        logic [31:0] b_imm;
        logic        br_inv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  wsrc;
        logic [31:0] wimm;
        logic        dmw;
        logic        dse;
        logic [1:0]  dacc;
        logic [1:0]  npc;
        logic [19:0] i20;
        logic [11:0] i12;
        logic        ill;
    } bundle_t;

    logic clk = 1'b0, rst = 1'b1;
    logic instr_valid = 1'b0, flush = 1'b0, ready = 1'b0;
    logic [31:0] instr = '0, pc = '0;
    logic instr_ready, valid, b_src, br_inv, dmw, dse, ill;
    logic [31:0] out_pc, b_imm, wimm;
    logic [5:0] alu_op;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] wsrc, dacc, npc;
    logic [19:0] i20;
    logic [11:0] i12;
    logic [2:0] level;
    bundle_t dut_b;

    int checks = 0, errors = 0;
    bundle_t exp_q[$];
    bit m_fifo[$];
    bit m_out_v = 0, m_out_ill = 0, m_trap = 0;

    instr_decode_rv_queued #(.QUEUE_DEPTH(D), .PC_WIDTH(32)) dut (
        .iwClk(clk), .iwRst(rst), .iwInstrValid(instr_valid), .iwInstr(instr), .iwPc(pc),
        .owInstrReady(instr_ready), .iwFlush(flush), .owValid(valid), .iwReady(ready),
        .owPc(out_pc), .orAluOp(alu_op), .owAluBSrc(b_src), .owAluBImmediate(b_imm),
        .owBranchInverted(br_inv), .owReadReg1(rs1), .owReadReg2(rs2), .owWriteReg(rd),
        .owWriteRegSource(wsrc), .orWriteRegImmediate(wimm), .owDMemWrite(dmw),
        .owDMemSignExtend(dse), .owDMemAccess(dacc), .owNextPcSrc(npc),
        .owNextPcImmediate20(i20), .owNextPcImmediate12(i12), .owIllegal(ill), .owLevel(level)
    );

    assign dut_b = {out_pc, alu_op, b_src, b_imm, br_inv, rs1, rs2, rd, wsrc, wimm,
                    dmw, dse, dacc, npc, i20, i12, ill};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode from the RV32I field definitions.
    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] p);
        bundle_t b;
        bit ok;
        int s, f3, f7, imm_i, imm_s;
        s     = $signed(w);
        imm_i = s >>> 20;
        imm_s = ((s >>> 20) & ~31) | ((s >> 7) & 31);
        f3    = int'((w >> 12) & 7);
        f7    = int'((w >> 25) & 127);
        b        = '0;
        b.pc     = p;
        b.rs1    = w[19:15];
        b.rs2    = w[24:20];
        b.i20    = 20'((((w >> 31) & 1) << 19) | (((w >> 12) & 255) << 11) | (((w >> 20) & 1) << 10) | ((w >> 21) & 1023));
        b.i12    = w[31:20];
        b.alu_op = 6'(A_ADD);
        ok = 1;
        case (w[6:0])
            7'h37: begin b.rd = w[11:7]; b.wsrc = 2; b.wimm = w & 32'hFFFFF000; end
            7'h17: begin b.rd = w[11:7]; b.wsrc = 2; b.wimm = (w & 32'hFFFFF000) + p; end
            7'h6F: begin b.rd = w[11:7]; b.wsrc = 2; b.wimm = p + 4; b.npc = 1; end
            7'h67: begin
                ok = (f3 == 0); b.rd = w[11:7]; b.wsrc = 2; b.wimm = p + 4; b.npc = 2;
                b.b_src = 1; b.b_imm = imm_i;
            end
            7'h63: begin
                ok = (f3 != 2) && (f3 != 3); b.npc = 3;
                b.i12 = 12'((((w >> 31) & 1) << 11) | (((w >> 7) & 1) << 10) | (((w >> 25) & 63) << 4) | ((w >> 8) & 15));
                b.alu_op = 6'((f3 < 2) ? A_SUB : (f3 < 6) ? A_SLT : A_SLTU);
                b.br_inv = f3[0];
            end
            7'h03: begin
                ok = (f3 inside {0, 1, 2, 4, 5}); b.rd = w[11:7]; b.wsrc = 1;
                b.b_src = 1; b.b_imm = imm_i; b.dse = (f3 < 3); b.dacc = 2'(f3 % 4);
            end
            7'h23: begin ok = (f3 < 3); b.dmw = 1; b.b_src = 1; b.b_imm = imm_s; b.dacc = 2'(f3); end
            7'h13: begin
                b.rd = w[11:7]; b.b_src = 1; b.b_imm = imm_i; b.alu_op = 6'(BASE[f3]);
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin ok = (f7 == 0) || (f7 == 32); b.alu_op = 6'((f7 == 32) ? A_SRA : A_SRL); end
            end
            7'h33: begin
                b.rd = w[11:7];
                if (f7 == 0) b.alu_op = 6'(BASE[f3]);
                else if (f7 == 32) begin ok = (f3 == 0) || (f3 == 5); b.alu_op = 6'((f3 == 0) ? A_SUB : A_SRA); end
                else if (f7 == 1 && MEXT) b.alu_op = 6'(A_MUL + f3);
                else ok = 0;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            b = '0; b.pc = p; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.ill = 1;
        end
        return b;
    endfunction

    // Occupancy/trap model: checks handshake signals, records accepted pushes.
    always @(negedge clk) begin
        bit exp_ready, acc;
        bundle_t e;
        if (rst) begin
            chk("reset_ready", 192'(instr_ready), 192'(0));
            chk("reset_valid", 192'(valid), 192'(0));
            chk("reset_level", 192'(level), 192'(0));
            chk("reset_bundle", 192'(dut_b), 192'(0));
            exp_q.delete(); m_fifo.delete(); m_out_v = 0; m_trap = 0;
        end else begin
            exp_ready = !m_trap && (m_fifo.size() < D) && !flush;
            chk("instr_ready", 192'(instr_ready), 192'(exp_ready));
            chk("valid", 192'(valid), 192'(m_out_v));
            chk("level", 192'(level), 192'(m_fifo.size()));
            if (flush) begin
                exp_q.delete(); m_fifo.delete(); m_out_v = 0; m_trap = 0;
            end else begin
                acc = m_out_v && ready;
                if (acc && m_out_ill) m_trap = 1;
                if (!m_trap && m_fifo.size() > 0 && (!m_out_v || ready)) begin
                    m_out_v = 1; m_out_ill = m_fifo.pop_front();
                end else if (acc) m_out_v = 0;
                if (instr_valid && exp_ready) begin
                    e = ref_decode(instr, pc);
                    exp_q.push_back(e);
                    m_fifo.push_back(e.ill);
                end
            end
        end
    end

    // Monitor: compares each bundle execute accepts against the scoreboard.
    always @(negedge clk) begin
        bundle_t e;
        if (!rst && valid && ready && !flush) begin
            if (exp_q.size() == 0) chk("unexpected_bundle", 192'(dut_b), 192'(0));
            else begin
                e = exp_q.pop_front();
                chk("bundle", 192'(dut_b), 192'(e));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] p);
        bit done = 0;
        instr_valid = 1; instr = w; pc = p;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (instr_ready) done = 1;
            @(posedge clk); #1;
        end
        instr_valid = 0;
        chk("push_accepted", 192'(done), 192'(1));
    endtask

    task automatic pulse_flush();
        flush = 1; idle(1); flush = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) begin
            w[6:0] = OPCS[k];
            if (k == 3 && $urandom_range(0, 3) != 0) w[14:12] = 3'b000;
            if (k == 8) begin
                case ($urandom_range(0, 3))
                    0, 1:    w[31:25] = 7'b0000000;
                    2:       w[31:25] = 7'b0100000;
                    default: w[31:25] = 7'b0000001;
                endcase
            end
        end
        return w;
    endfunction

    initial begin
        idle(3);
        rst = 0;
        ready = 1;
        push(32'h00500093, 32'h100);
        idle(3);
        push(32'h12345137, 32'h200);
        push(32'h00112423, 32'h204);
        idle(3);
        ready = 0;
        for (int k = 0; k < 5; k++) push(32'h00100013 | (32'(k + 1) << 7), 32'h300 + 32'(4 * k));
        fork
            begin repeat (4) @(posedge clk); #1 ready = 1; end
        join_none
        push(32'h00600313, 32'h314);
        idle(8);
        push(32'h00000000, 32'h400);
        push(32'h00500093, 32'h404);
        idle(4);
        pulse_flush();
        idle(2);
        ready = 0;
        push(32'h00100093, 32'h500);
        push(32'h00200113, 32'h504);
        push(32'h00300193, 32'h508);
        instr_valid = 1; instr = 32'h00400213; pc = 32'h50C; flush = 1;
        idle(1);
        flush = 0; instr_valid = 0;
        idle(2);
        ready = 1;
        idle(3);
        push(32'h022081B3, 32'h600);
        idle(4);
        pulse_flush();
        idle(2);
        pc = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            ready       = ($urandom_range(0, 3) != 0);
            instr_valid = ($urandom_range(0, 2) != 0);
            instr       = rand_instr();
            pc          = pc + 4;
            flush       = m_trap ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            rst         = (c == 200 || c == 201);
            idle(1);
        end
        instr_valid = 0; ready = 1; rst = 0;
        flush = m_trap;
        idle(1);
        flush = 0;
        idle(20);
        chk("drain_empty", 192'(exp_q.size()), 192'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_decode_rv_queued.md
Name: instr_decode_rv_queued

Overview:
Decode stage for the RV32I core, placed between instruction fetch and execute. Buffers fetched {instr, pc} pairs in a parametrised queue and decodes the head entry. Drives a registered control bundle to execute under a valid/ready handshake. Adds flush and a sticky illegal-instruction trap state that the previous combinational decoder lacked.

Parameters:
QUEUE_DEPTH, 4, number of {instr, pc} entries buffered; power of two, 2..16
PC_WIDTH, 32, width of PC carried with each entry and used for AUIPC/JAL/JALR link values

Ports:
iwClk  input  1  clock, rising edge
iwRst  input  1  asynchronous reset, active-high
iwInstrValid  input  1  fetch offers an instruction
iwInstr  input  32  instruction word
iwPc  input  PC_WIDTH  PC of iwInstr
owInstrReady  output  1  queue can accept
iwFlush  input  1  synchronous flush: redirect or trap handled
owValid  output  1  decoded bundle valid
iwReady  input  1  execute accepts bundle
owPc  output  PC_WIDTH  PC of decoded instruction
orAluOp  output  6  ALU_OP_* code from the shared ALU op macro file
owAluBSrc  output  1  ALU_B_SOURCE_REG / ALU_B_SOURCE_IMMEDIATE
owAluBImmediate  output  32  sign-extended I- or S-immediate, else 0
owBranchInverted  output  1  BNE/BGE/BGEU
owReadReg1, owReadReg2  output  5  rs1, rs2
owWriteReg  output  5  rd, or 0 when there is no write or the instruction is illegal
owWriteRegSource  output  2  REG_SOURCE_ALU / MEMORY / IMMEDIATE
orWriteRegImmediate  output  32  LUI/AUIPC value or pc+4
owDMemWrite  output  1  store; 0 if illegal
owDMemSignExtend  output  1  LB/LH/LW
owDMemAccess  output  2  MEM_ACCESS_BYTE / HALF_WORD / WORD
owNextPcSrc  output  2  NEXT_PC_SRC_SEQ / JAL / JALR / B
owNextPcImmediate20  output  20  J-immediate field
owNextPcImmediate12  output  12  B-immediate for BRANCH, else I-immediate
owIllegal  output  1  bundle is an illegal instruction; qualified by owValid
owLevel  output  $clog2(QUEUE_DEPTH)+1  queue occupancy

Behaviour:
- Reset (async, iwRst=1): queue empty, owLevel=0, owValid=0, every bundle output 0, owIllegal=0, state RUN. owInstrReady=0 while in reset.
- Queue: circular buffer with read and write pointers of $clog2(QUEUE_DEPTH) bits, wrapping modulo QUEUE_DEPTH.
  - Push when iwInstrValid && owInstrReady.
  - owInstrReady = (owLevel<QUEUE_DEPTH) && state==RUN && !iwFlush.
  - Push and pop in the same cycle while full is allowed only if the pop frees the slot. owInstrReady does not look ahead: it stays 0 when full.
- Output register: loaded from the combinational decode of the queue head when the queue is non-empty and (!owValid || iwReady). The head is popped in the same cycle. owValid drops when iwReady && owValid and the queue is empty.
- Latency: an instruction pushed at edge k appears on the outputs after edge k+1 when the queue and output register are empty. Throughput is 1 per cycle.
- Output stability: bundle outputs are held stable while owValid && !iwReady.
- Decode rules:
  - Opcodes: LUI, AUIPC, JAL, JALR (funct3=000), BRANCH, LOAD, STORE, OP_IMM, OP.
  - Unsupported funct3/funct7 combinations or opcodes set owIllegal=1, orAluOp=ALU_OP_ADD, owWriteReg=0, owDMemWrite=0, owNextPcSrc=SEQ.
  - AUIPC: {imm20,12'h0}+pc, truncated to 32 bits. JAL/JALR link: pc+4.
- State machine:
  - RUN→TRAP when a bundle with owIllegal=1 is accepted (owValid && iwReady && owIllegal).
  - In TRAP, no pushes are accepted. The queue contents are retained but not decoded, and owValid=0.
  - TRAP→RUN only on iwFlush.
- iwFlush, on the next edge: queue empty, owValid=0, state=RUN.
  - Flush overrides a simultaneous push or pop; the pushed instruction is dropped.
  - iwReady is ignored in a flush cycle.
- Reset mid-operation discards everything immediately.

Optional Feature:
Macro ICE_RISCV_M_EXT_EN.
- Defined: OP with funct7=0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by funct3 to ALU_OP_MUL..ALU_OP_REMU. These use owWriteRegSource=REG_SOURCE_ALU and owAluBSrc=REG.
- Not defined: those encodings are illegal and enter TRAP when consumed.

Test Plan:
- Reset release, push 0x00500093 (addi x1,x0,5) at pc 0x100, iwReady=1 → one cycle later: owValid=1, orAluOp=ALU_OP_ADD, owAluBImmediate=5, owWriteReg=1, owIllegal=0.
- Push 0x12345137 (lui x2) at pc 0x200 then 0x00112423 (sw x1,8(x2)) → bundle 1: orWriteRegImmediate=0x12345000, owWriteReg=2. Bundle 2: owDMemWrite=1, owAluBImmediate=8, owWriteReg=0, owDMemAccess=WORD.
- QUEUE_DEPTH=4, iwReady=0, push 6 instructions back to back → 1 in output register, owLevel=4, owInstrReady=0. Raise iwReady → in-order drain, one per cycle, across pointer wrap.
- Push 0x00000000 then 0x00500093 → first bundle: owIllegal=1, owWriteReg=0. After acceptance, state TRAP: owValid=0 and owInstrReady=0. Pulse iwFlush → owLevel=0, owInstrReady=1.
- iwFlush asserted in the same cycle as a push with owLevel=2 → next cycle owLevel=0, owValid=0, pushed instruction never appears.
- Push 0x022081B3 (mul x3,x1,x2) → with ICE_RISCV_M_EXT_EN: orAluOp=ALU_OP_MUL, owWriteReg=3. Without it: owIllegal=1, then TRAP.
